// File: rtl/dpwm_ramp_gen.sv
// DPWM carrier/compare generator: sawtooth or triangle ramp with duty compare.
// Optional DPWM_SHADOW_EN latches period/step/duty/mode only at period boundaries.
module dpwm_ramp_gen #(
  parameter int W = 10
) (
  input  logic         CLK,
  input  logic         reset,
  input  logic         en,
  input  logic         mode,
  input  logic [W-1:0] period,
  input  logic [W-1:0] step,
  input  logic [W-1:0] duty,
  output logic [W-1:0] cuenta,
  output logic         dir,
  output logic         pwm_out,
  output logic         period_end
);

  logic [W-1:0] p_act;
  logic [W-1:0] s_raw;
  logic [W-1:0] d_act;
  logic         m_act;
  logic [W-1:0] d_nxt;

  logic [W-1:0] s_eff;
  logic [W:0]   sum;
  logic [W:0]   p_ext;

  logic [W-1:0] cnt_nxt;
  logic         dir_nxt;
  logic         pe_nxt;
  logic         pwm_nxt;

`ifdef DPWM_SHADOW_EN
  logic [W-1:0] period_q;
  logic [W-1:0] step_q;
  logic [W-1:0] duty_q;
  logic         mode_q;
  logic         load;

  // Reload on the same edge that returns the carrier to zero.
  assign load = reset | pe_nxt;

  always_ff @(posedge CLK) begin
    if (load) begin
      period_q <= period;
      step_q   <= step;
      duty_q   <= duty;
      mode_q   <= mode;
    end
  end

  assign p_act = period_q;
  assign s_raw = step_q;
  assign d_act = duty_q;
  assign m_act = mode_q;
  assign d_nxt = load ? duty : duty_q;
`else
  assign p_act = period;
  assign s_raw = step;
  assign d_act = duty;
  assign m_act = mode;
  assign d_nxt = d_act;
`endif

  assign s_eff = (s_raw == '0) ? W'(1) : s_raw;
  assign sum   = {1'b0, cuenta} + {1'b0, s_eff};
  assign p_ext = {1'b0, p_act};

  always_comb begin
    cnt_nxt = cuenta;
    dir_nxt = dir;
    pe_nxt  = 1'b0;
    if (en) begin
      if (p_act == '0) begin
        cnt_nxt = '0;
        dir_nxt = 1'b1;
        pe_nxt  = 1'b1;
      end else if (!m_act) begin
        dir_nxt = 1'b1;
        if (cuenta >= p_act) begin
          cnt_nxt = '0;
          pe_nxt  = 1'b1;
        end else if (sum > p_ext) begin
          cnt_nxt = p_act;
        end else begin
          cnt_nxt = sum[W-1:0];
        end
      end else if (dir) begin
        if (cuenta >= p_act || sum >= p_ext) begin
          cnt_nxt = p_act;
          dir_nxt = 1'b0;
        end else begin
          cnt_nxt = sum[W-1:0];
        end
      end else begin
        if (cuenta <= s_eff) begin
          cnt_nxt = '0;
          dir_nxt = 1'b1;
          pe_nxt  = 1'b1;
        end else begin
          cnt_nxt = cuenta - s_eff;
        end
      end
    end
  end

  // Compare against the next count so pwm_out lines up with cuenta.
  assign pwm_nxt = (cnt_nxt < d_nxt);

  always_ff @(posedge CLK) begin
    if (reset) begin
      cuenta     <= '0;
      dir        <= 1'b1;
      pwm_out    <= 1'b0;
      period_end <= 1'b0;
    end else begin
      cuenta     <= cnt_nxt;
      dir        <= dir_nxt;
      pwm_out    <= pwm_nxt;
      period_end <= pe_nxt;
    end
  end

endmodule

// File: tb/tb_dpwm_ramp_gen.sv
// Scoreboard bench for dpwm_ramp_gen (default build, live active values).
module tb_dpwm_ramp_gen;
  localparam int W = 10;

  logic         CLK;
  logic         reset;
  logic         en;
  logic         mode;
  logic [W-1:0] period;
  logic [W-1:0] step;
  logic [W-1:0] duty;
  logic [W-1:0] cuenta;
  logic         dir;
  logic         pwm_out;
  logic         period_end;

  dpwm_ramp_gen #(.W(W)) dut (
    .CLK(CLK),
    .reset(reset),
    .en(en),
    .mode(mode),
    .period(period),
    .step(step),
    .duty(duty),
    .cuenta(cuenta),
    .dir(dir),
    .pwm_out(pwm_out),
    .period_end(period_end)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int cnt;
    int dir;
    int pwm;
    int pe;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad = 0;
  int m_cnt = 0;
  int m_dir = 1;
  int last_cnt, last_dir, last_pwm, last_pe;

  task automatic chk(input string tag, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  task automatic model_push();
    exp_t e;
    int p, s, d;
    p = int'(period);
    s = (step == 0) ? 1 : int'(step);
    d = int'(duty);
    e.pe = 0;
    e.pwm = 0;
    if (reset) begin
      m_cnt = 0;
      m_dir = 1;
    end else begin
      if (en) begin
        if (p == 0) begin
          m_cnt = 0;
          m_dir = 1;
          e.pe = 1;
        end else if (!mode) begin
          m_dir = 1;
          if (m_cnt >= p) begin
            m_cnt = 0;
            e.pe = 1;
          end else begin
            m_cnt = (m_cnt + s > p) ? p : m_cnt + s;
          end
        end else if (m_dir == 1) begin
          if (m_cnt + s >= p) begin
            m_cnt = p;
            m_dir = 0;
          end else begin
            m_cnt = m_cnt + s;
          end
        end else if (m_cnt <= s) begin
          m_cnt = 0;
          m_dir = 1;
          e.pe = 1;
        end else begin
          m_cnt = m_cnt - s;
        end
      end
      e.pwm = (m_cnt < d) ? 1 : 0;
    end
    e.cnt = m_cnt;
    e.dir = m_dir;
    sbq.push_back(e);
  endtask

  task automatic cyc();
    exp_t e;
    model_push();
    @(posedge CLK);
    #1;
    e = sbq.pop_front();
    last_cnt = int'(cuenta);
    last_dir = int'(dir);
    last_pwm = int'(pwm_out);
    last_pe  = int'(period_end);
    chk("sb_cuenta", last_cnt, e.cnt);
    chk("sb_dir", last_dir, e.dir);
    chk("sb_pwm", last_pwm, e.pwm);
    chk("sb_pe", last_pe, e.pe);
  endtask

  task automatic run_until(input int v, input int budget);
    for (int i = 0; i < budget && last_cnt != v; i++) cyc();
    chk("reach", last_cnt, v);
  endtask

  int hi, pes;
  int tt[10] = '{0, 300, 600, 900, 1000, 700, 400, 100, 0, 300};
  int td[10] = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1};
  int tp[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};

  initial begin
    reset = 1'b1;
    en = 1'b0;
    mode = 1'b0;
    period = 10'd1000;
    step = 10'd50;
    duty = 10'd500;
    last_cnt = 0;
    repeat (2) cyc();
    chk("rst_cnt", last_cnt, 0);
    chk("rst_dir", last_dir, 1);
    chk("rst_pwm", last_pwm, 0);
    chk("rst_pe", last_pe, 0);

    reset = 1'b0;
    en = 1'b1;
    hi = 0;
    pes = 0;
    for (int i = 0; i < 21; i++) begin
      cyc();
      hi += last_pwm;
      pes += last_pe;
      if (i == 19) chk("saw_peak", last_cnt, 1000);
    end
    chk("saw_hi", hi, 10);
    chk("saw_pe", pes, 1);
    chk("saw_wrap", last_cnt, 0);

    run_until(450, 40);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("hold_cnt", last_cnt, 450);
      chk("hold_pwm", last_pwm, 1);
      chk("hold_pe", last_pe, 0);
    end
    en = 1'b1;
    cyc();
    chk("resume", last_cnt, 500);

    run_until(300, 40);
    duty = 10'd200;
    cyc();
    chk("duty_cnt", last_cnt, 350);
    chk("duty_pwm", last_pwm, 0);
    duty = 10'd500;

    reset = 1'b1;
    mode = 1'b1;
    step = 10'd300;
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) cyc();
      chk("tri_cnt", last_cnt, tt[i]);
      chk("tri_dir", last_dir, td[i]);
      chk("tri_pe", last_pe, tp[i]);
    end

    run_until(700, 20);
    chk("dn_dir", last_dir, 0);
    reset = 1'b1;
    cyc();
    chk("rst2_cnt", last_cnt, 0);
    chk("rst2_dir", last_dir, 1);
    chk("rst2_pwm", last_pwm, 0);
    chk("rst2_pe", last_pe, 0);
    reset = 1'b0;

    mode = 1'b0;
    period = 10'd5;
    step = 10'd0;
    for (int i = 1; i <= 6; i++) begin
      cyc();
      chk("s0_cnt", last_cnt, i % 6);
    end

    period = 10'd0;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) mode = 1'b1;
      cyc();
      chk("p0_cnt", last_cnt, 0);
      chk("p0_pe", last_pe, 1);
    end

    mode = 1'b0;
    period = 10'd1000;
    step = 10'd50;
    duty = 10'd0;
    hi = 0;
    for (int i = 0; i < 25; i++) begin
      cyc();
      hi += last_pwm;
    end
    chk("d0_hi", hi, 0);
    duty = 10'd1023;
    hi = 0;
    for (int i = 0; i < 25; i++) begin
      cyc();
      hi += last_pwm;
    end
    chk("dmax_hi", hi, 25);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      if ($urandom_range(0, 19) == 0) period = 10'($urandom_range(0, 60));
      if ($urandom_range(0, 9) == 0) step = 10'($urandom_range(0, 12));
      if ($urandom_range(0, 7) == 0) duty = 10'($urandom_range(0, 70));
      en = ($urandom_range(0, 7) != 0);
      reset = ($urandom_range(0, 99) == 0);
      cyc();
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got 1 want 0");
    $fatal(1, "timeout");
  end

endmodule
